// File: rtl/spi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter_if
// Brief    : Requester-side and SPI-side bus bundle for the SPI arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [NREQ-1:0]        req_in;
    logic [NREQ-1:0]        we_in;
    logic [NREQ-1:0]        ext_in;
    logic [NREQ*DATA_W-1:0] wdata_in;
    logic [NREQ-1:0]        gnt_out;
    logic [NREQ-1:0]        done_out;
    logic                   err_out;
    logic [DATA_W-1:0]      rdata_out;
    logic [ADDR_W-1:0]      raddr_out;
    logic                   busy_out;
    logic                   spi_send_out;
    logic                   spi_read_out;
    logic                   spi_drv_out;
    logic [DATA_W-1:0]      spi_data_out;
    logic                   spi_ready_in;
    logic [DATA_W-1:0]      spi_data_in;
    logic [ADDR_W-1:0]      spi_addr_in;

    // The arbiter itself: serves requesters and drives the SPI block.
    modport slave (
        input  req_in, we_in, ext_in, wdata_in,
        input  spi_ready_in, spi_data_in, spi_addr_in,
        output gnt_out, done_out, err_out, rdata_out, raddr_out, busy_out,
        output spi_send_out, spi_read_out, spi_drv_out, spi_data_out
    );

    modport master (
        output req_in, we_in, ext_in, wdata_in,
        output spi_ready_in, spi_data_in, spi_addr_in,
        input  gnt_out, done_out, err_out, rdata_out, raddr_out, busy_out,
        input  spi_send_out, spi_read_out, spi_drv_out, spi_data_out
    );
endinterface
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Brief    : Round-robin sharing of one SPI block between NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
    parameter int NREQ    = 2,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 32,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    spi_arbiter_if.slave  bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_l_q, gnt_l_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                we_l_q, we_l_d;
    logic                ext_l_q, ext_l_d;
    logic                err_l_q, err_l_d;
    logic [DATA_W-1:0]   wdata_l_q, wdata_l_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [NREQ-1:0]     gnt_out_q, gnt_out_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                err_out_q, err_out_d;
    logic                busy_q, busy_d;
    logic                send_q, send_d;
    logic                read_q, read_d;
    logic                drv_q, drv_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;

    logic                found;
    logic [IDX_W-1:0]    sel;
    logic                sel_we;
    logic                sel_ext;
    logic [DATA_W-1:0]   sel_wdata;
    logic [NREQ-1:0]     sel_onehot;

    // Round-robin pick: first requester at distance 1..NREQ from the last winner.
    always_comb begin
        found     = 1'b0;
        sel       = last_q;
        sel_we    = 1'b0;
        sel_ext   = 1'b0;
        sel_wdata = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && bus.req_in[i] && (((int'(last_q) + k) % NREQ) == i)) begin
                    found     = 1'b1;
                    sel       = IDX_W'(i);
                    sel_we    = bus.we_in[i];
                    sel_ext   = bus.ext_in[i];
                    sel_wdata = bus.wdata_in[i*DATA_W +: DATA_W];
                end
            end
        end
        sel_onehot = NREQ'(1) << sel;
    end

    // Output flops are loaded with the values belonging to the next state.
    always_comb begin
        state_d   = state_q;
        gnt_l_d   = gnt_l_q;
        idx_d     = idx_q;
        last_d    = last_q;
        we_l_d    = we_l_q;
        ext_l_d   = ext_l_q;
        err_l_d   = err_l_q;
        wdata_l_d = wdata_l_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        raddr_d   = raddr_q;
        gnt_out_d = '0;
        done_d    = '0;
        err_out_d = 1'b0;
        send_d    = 1'b0;
        read_d    = 1'b0;
        drv_d     = 1'b0;
        sdata_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d   = S_ISSUE;
                    idx_d     = sel;
                    gnt_l_d   = sel_onehot;
                    we_l_d    = sel_we;
                    ext_l_d   = sel_ext;
                    wdata_l_d = sel_wdata;
                    gnt_out_d = sel_onehot;
                    send_d    = sel_we;
                    read_d    = ~sel_we;
                    drv_d     = sel_ext;
                    sdata_d   = sel_wdata;
                end
            end
            S_ISSUE: begin
                state_d   = S_WAIT;
                cnt_d     = '0;
                gnt_out_d = gnt_l_q;
                read_d    = ~we_l_q;
                drv_d     = ext_l_q;
                sdata_d   = wdata_l_q;
            end
            S_WAIT: begin
                cnt_d = cnt_q + TO_W'(1);
                if (bus.spi_ready_in) begin
                    if (!we_l_q) begin
                        rdata_d = bus.spi_data_in;
                        raddr_d = bus.spi_addr_in;
                    end
                    err_l_d   = 1'b0;
                    state_d   = S_DONE;
                    gnt_out_d = gnt_l_q;
                    done_d    = gnt_l_q;
                    err_out_d = 1'b0;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_l_d   = 1'b1;
                    state_d   = S_DONE;
                    gnt_out_d = gnt_l_q;
                    done_d    = gnt_l_q;
                    err_out_d = 1'b1;
                end else begin
                    gnt_out_d = gnt_l_q;
                    read_d    = ~we_l_q;
                    drv_d     = ext_l_q;
                    sdata_d   = wdata_l_q;
                end
            end
            S_DONE: begin
                last_d  = idx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_l_q   <= '0;
            idx_q     <= '0;
            last_q    <= IDX_W'(NREQ - 1);
            we_l_q    <= 1'b0;
            ext_l_q   <= 1'b0;
            err_l_q   <= 1'b0;
            wdata_l_q <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            gnt_out_q <= '0;
            done_q    <= '0;
            err_out_q <= 1'b0;
            busy_q    <= 1'b0;
            send_q    <= 1'b0;
            read_q    <= 1'b0;
            drv_q     <= 1'b0;
            sdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_l_q   <= gnt_l_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            we_l_q    <= we_l_d;
            ext_l_q   <= ext_l_d;
            err_l_q   <= err_l_d;
            wdata_l_q <= wdata_l_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            raddr_q   <= raddr_d;
            gnt_out_q <= gnt_out_d;
            done_q    <= done_d;
            err_out_q <= err_out_d;
            busy_q    <= busy_d;
            send_q    <= send_d;
            read_q    <= read_d;
            drv_q     <= drv_d;
            sdata_q   <= sdata_d;
        end
    end

    assign bus.gnt_out      = gnt_out_q;
    assign bus.done_out     = done_q;
    assign bus.err_out      = err_out_q;
    assign bus.rdata_out    = rdata_q;
    assign bus.raddr_out    = raddr_q;
    assign bus.busy_out     = busy_q;
    assign bus.spi_send_out = send_q;
    assign bus.spi_read_out = read_q;
    assign bus.spi_drv_out  = drv_q;
    assign bus.spi_data_out = sdata_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Brief    : Directed plus random checks of spi_arbiter against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;
    localparam int NREQ    = 2;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    spi_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Transaction timeline model: start cycle, done cycle, latched request.
    bit          m_act = 1'b0;
    int          m_s, m_d, m_idx;
    int          m_can  = 0;
    int          m_last = NREQ - 1;
    bit          m_we, m_ext, m_err;
    logic [7:0]  m_wd;
    logic [7:0]  m_rdata = '0;
    logic [3:0]  m_raddr = '0;

    // SPI block stand-in.
    bit          r_arm = 1'b0, r_dead = 1'b0;
    int          r_s, r_n;
    logic [1:0]  r_prev = '0;
    bit          next_dead = 1'b0;
    bit          force_en  = 1'b0;
    logic [7:0]  force_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic       sn_rst;
        logic [1:0] sn_req, sn_we, sn_ext;
        logic [15:0] sn_wd;
        logic [7:0] sn_sd;
        logic [3:0] sn_sa;
        logic [1:0] e_gnt, e_done;
        logic       e_err, e_busy, e_send, e_read, e_drv;
        logic [7:0] e_data;
        bit         in_win, mid;
        sn_rst = rst;          sn_req = bus.req_in;   sn_we = bus.we_in;
        sn_ext = bus.ext_in;   sn_wd  = bus.wdata_in;
        sn_sd  = bus.spi_data_in; sn_sa = bus.spi_addr_in;
        @(negedge clk);
        cyc++;
        if (sn_rst) begin
            m_act = 1'b0; m_last = NREQ - 1; m_rdata = '0; m_raddr = '0; m_can = cyc + 1;
        end else begin
            if (m_act && cyc == m_d) begin
                if (!m_we && !m_err) begin
                    m_rdata = sn_sd;
                    m_raddr = sn_sa;
                end
                m_last = m_idx;
                m_can  = m_d + 2;
            end
            if (!m_act && cyc >= m_can && sn_req != 2'b00) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int j;
                    j = (m_last + k) % NREQ;
                    if (!m_act && sn_req[j]) begin
                        m_act = 1'b1;
                        m_idx = j;
                    end
                end
                m_s   = cyc;
                m_we  = sn_we[m_idx];
                m_ext = sn_ext[m_idx];
                m_wd  = sn_wd[m_idx*8 +: 8];
                m_err = next_dead;
                m_d   = m_err ? cyc + TIMEOUT + 1 : cyc + (m_ext ? DATA_W + ADDR_W : 8) + 1;
            end
        end
        in_win = m_act && cyc >= m_s && cyc <= m_d;
        mid    = m_act && cyc >= m_s && cyc < m_d;
        e_gnt  = in_win ? 2'(1 << m_idx) : 2'b00;
        e_done = (m_act && cyc == m_d) ? 2'(1 << m_idx) : 2'b00;
        e_err  = m_act && cyc == m_d && m_err;
        e_busy = in_win;
        e_send = m_act && cyc == m_s && m_we;
        e_read = mid && !m_we;
        e_drv  = mid && m_ext;
        e_data = mid ? m_wd : 8'h00;
        check($sformatf("ctrl@%0d", cyc),
              32'({bus.gnt_out, bus.done_out, bus.err_out, bus.busy_out,
                   bus.spi_send_out, bus.spi_read_out, bus.spi_drv_out}),
              32'({e_gnt, e_done, e_err, e_busy, e_send, e_read, e_drv}));
        check($sformatf("spi_data@%0d", cyc), 32'(bus.spi_data_out), 32'(e_data));
        check($sformatf("rdata@%0d", cyc), 32'(bus.rdata_out), 32'(m_rdata));
        check($sformatf("raddr@%0d", cyc), 32'(bus.raddr_out), 32'(m_raddr));
        if (m_act && cyc == m_d) m_act = 1'b0;

        // SPI stand-in: ready N cycles after ISSUE, N taken from the driver mode it sees.
        if (bus.gnt_out != 2'b00 && r_prev == 2'b00) begin
            r_arm  = 1'b1;
            r_s    = cyc;
            r_n    = bus.spi_drv_out ? DATA_W + ADDR_W : 8;
            r_dead = next_dead;
        end
        if (bus.gnt_out == 2'b00) r_arm = 1'b0;
        bus.spi_ready_in = r_arm && !r_dead && (cyc == r_s + r_n);
        bus.spi_data_in  = force_en ? force_val : 8'($urandom);
        bus.spi_addr_in  = 4'($urandom);
        r_prev = bus.gnt_out;
    endtask

    task automatic wait_done(input int i, input int budget, output int at);
        bit got;
        got = 1'b0;
        at  = -1;
        for (int k = 0; k < budget && !got; k++) begin
            step();
            if (bus.done_out[i] === 1'b1) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        check($sformatf("done_seen_%0d", i), 32'(got), 32'd1);
    endtask

    task automatic wait_gnt(input int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            step();
            if (bus.gnt_out != 2'b00) got = 1'b1;
        end
        check("gnt_seen", 32'(got), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, at, idx;
        bit got;
        logic [1:0] pend;
        bus.req_in = '0; bus.we_in = '0; bus.ext_in = '0; bus.wdata_in = '0;
        bus.spi_ready_in = 1'b0; bus.spi_data_in = '0; bus.spi_addr_in = '0;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Requester 0 reads, ext=0, SPI returns 0xA5.
        force_en = 1'b1; force_val = 8'hA5;
        bus.we_in = 2'b00; bus.ext_in = 2'b00; bus.req_in = 2'b01;
        t0 = cyc;
        wait_done(0, 40, at);
        check("t1_latency", 32'(at - t0), 32'd10);
        check("t1_rdata", 32'(bus.rdata_out), 32'h A5);
        check("t1_err", 32'(bus.err_out), 32'd0);
        bus.req_in = 2'b00;
        force_en = 1'b0;
        step();

        // Requester 1 sends 0x3C with ext=1.
        bus.wdata_in[15:8] = 8'h3C; bus.we_in = 2'b10; bus.ext_in = 2'b10; bus.req_in = 2'b10;
        t0 = cyc;
        wait_done(1, 40, at);
        check("t2_latency", 32'(at - t0), 32'd14);
        check("t2_rdata_kept", 32'(bus.rdata_out), 32'h A5);
        bus.req_in = 2'b00;
        step();

        // Both hold requests: grants must alternate starting with 0.
        bus.we_in = 2'b00; bus.ext_in = 2'b00; bus.req_in = 2'b11;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0; idx = -1;
            for (int k = 0; k < 40 && !got; k++) begin
                step();
                if (bus.done_out != 2'b00) begin
                    got = 1'b1;
                    idx = (bus.done_out == 2'b01) ? 0 : ((bus.done_out == 2'b10) ? 1 : -1);
                end
            end
            check($sformatf("t3_order_%0d", n), 32'(idx), 32'(n % 2));
        end
        bus.req_in = 2'b00;
        step();

        // SPI never ready: timeout with err, then a normal transaction.
        next_dead = 1'b1;
        bus.req_in = 2'b01;
        t0 = cyc;
        wait_done(0, 60, at);
        check("t4_to_latency", 32'(at - t0), 32'(TIMEOUT + 2));
        check("t4_err", 32'(bus.err_out), 32'd1);
        bus.req_in = 2'b00;
        next_dead = 1'b0;
        step();
        bus.req_in = 2'b01;
        t0 = cyc;
        wait_done(0, 40, at);
        check("t4_recover_latency", 32'(at - t0), 32'd10);
        check("t4_recover_err", 32'(bus.err_out), 32'd0);
        bus.req_in = 2'b00;
        step();

        // Reset during the third WAIT cycle; priority returns to requester 0.
        bus.req_in = 2'b01;
        wait_gnt(10);
        check("t5_first_gnt", 32'(bus.gnt_out), 32'd1);
        repeat (3) step();
        rst = 1'b1; bus.req_in = 2'b11;
        step();
        check("t5_rst_outputs",
              32'({bus.gnt_out, bus.done_out, bus.err_out, bus.busy_out,
                   bus.spi_send_out, bus.spi_read_out, bus.spi_drv_out, bus.spi_data_out}),
              32'd0);
        rst = 1'b0;
        step();
        check("t5_prio", 32'(bus.gnt_out), 32'd1);
        bus.req_in = 2'b10;
        wait_done(0, 40, at);
        wait_done(1, 40, at);
        bus.req_in = 2'b00;
        step();

        // Granted requester drops req in WAIT while the other raises.
        bus.req_in = 2'b01;
        wait_gnt(10);
        step();
        bus.req_in = 2'b10;
        wait_done(0, 40, at);
        wait_gnt(10);
        check("t6_next_gnt", 32'(bus.gnt_out), 32'd2);
        wait_done(1, 40, at);
        bus.req_in = 2'b00;
        step();

        // Random traffic obeying the requester rules.
        pend = 2'b00;
        for (int n = 0; n < 600; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && bus.done_out[i]) begin
                    pend[i] = 1'b0;
                    bus.req_in[i] = 1'b0;
                end else if (pend[i] && bus.gnt_out[i] && ($urandom % 4 == 0)) begin
                    bus.req_in[i] = 1'b0;
                end
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    bus.req_in[i] = 1'b1;
                    bus.we_in[i]  = 1'($urandom);
                    bus.ext_in[i] = 1'($urandom);
                    bus.wdata_in[i*8 +: 8] = 8'($urandom);
                end
            end
            next_dead = ($urandom % 8 == 0);
        end
        next_dead = 1'b0;
        for (int n = 0; n < 120 && pend != 2'b00; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && bus.done_out[i]) begin
                    pend[i] = 1'b0;
                    bus.req_in[i] = 1'b0;
                end
            end
        end
        check("drain", 32'(pend), 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
